// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared defaults and flag helper for the RAM-backed FIFO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_fifo_ctrl_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_ADDR     = 4;
   localparam int DEF_DEPTH    = 1 << DEF_ADDR;
   localparam int DEF_AF_LEVEL = 14;
   localparam int DEF_AE_LEVEL = 2;
   localparam int DEF_CNT_W    = DEF_ADDR + 1;

   // Occupancy-derived status, kept together so it is registered as one unit.
   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   // All four status flags from an occupancy value; int arguments keep this
   // independent of the parameterised count width.
   function automatic fifo_flags_t calc_flags(input int cnt, input int depth,
                                              input int af_lvl, input int ae_lvl);
      fifo_flags_t f;
      f.full         = (cnt == depth);
      f.empty        = (cnt == 0);
      f.almost_full  = (cnt >= af_lvl);
      f.almost_empty = (cnt <= ae_lvl);
      return f;
   endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop stream and status bundle between a FIFO user and the FIFO.
// Latency: n/a (wiring only).
// Backpressure: the user must watch full/empty; rejected requests only set sticky errors.
interface ram_fifo_ctrl_if
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ADDR  = DEF_ADDR
);
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [ADDR:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/ram_fifo_ctrl_dual_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: 1 cycle from re to dout; dout holds when re is low.
// Backpressure: none; the controller guarantees no same-address read/write.
module dual_ram #(
   parameter int WIDTH = 8,
   parameter int ADDR  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [ADDR-1:0]  wr_addr,
   input  logic [WIDTH-1:0] din,
   input  logic             re,
   input  logic [ADDR-1:0]  rd_addr,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [0:(1<<ADDR)-1];

   // Storage write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= din;
      end
   end

   // Registered read port; output cleared on reset, held between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
      end else if (re) begin
         dout <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller turning push/pop requests into dual_ram addresses and enables.
// Latency: 1 cycle from accepted pop to rd_valid/rd_data; flags update with pointers.
// Backpressure: push while full / pop while empty are dropped and latched as overflow/underflow.
module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR     = DEF_ADDR,
   parameter int AF_LEVEL = DEF_AF_LEVEL,
   parameter int AE_LEVEL = DEF_AE_LEVEL
) (
   input  logic             clk,
   input  logic             rst,
   ram_fifo_ctrl_if.slave   bus
);

   localparam logic [ADDR:0] PTR_ONE = (ADDR+1)'(1);

   // Pointers carry one extra wrap bit; low ADDR bits address the RAM.
   logic [ADDR:0]    wr_ptr, rd_ptr;
   logic [ADDR:0]    wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
   logic [ADDR:0]    cnt_q;
   fifo_flags_t      flg_q;
   logic             rd_valid_q;
   logic             ovf_q, udf_q;
   logic             wr_acc, rd_acc;
   logic [WIDTH-1:0] ram_dout;

   // Acceptance uses flags registered at the start of the cycle, so a same-cycle
   // pop never frees room for a push and a same-cycle push never feeds a pop.
   assign wr_acc = bus.wr_en & ~flg_q.full;
   assign rd_acc = bus.rd_en & ~flg_q.empty;

   // Next pointer values and the occupancy they imply (modular difference).
   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      if (wr_acc) begin
         wr_ptr_nxt = wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
         rd_ptr_nxt = rd_ptr + PTR_ONE;
      end
      cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;
   end

   // Pointer, count, flag, read-valid and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt_q      <= '0;
         flg_q      <= calc_flags(0, DEPTH, AF_LEVEL, AE_LEVEL);
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         cnt_q      <= cnt_nxt;
         flg_q      <= calc_flags(int'(cnt_nxt), DEPTH, AF_LEVEL, AE_LEVEL);
         rd_valid_q <= rd_acc;
         ovf_q      <= ovf_q | (bus.wr_en & flg_q.full);
         udf_q      <= udf_q | (bus.rd_en & flg_q.empty);
      end
   end

   dual_ram #(
      .WIDTH (WIDTH),
      .ADDR  (ADDR)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_acc),
      .wr_addr (wr_ptr[ADDR-1:0]),
      .din     (bus.wr_data),
      .re      (rd_acc),
      .rd_addr (rd_ptr[ADDR-1:0]),
      .dout    (ram_dout)
   );

   assign bus.rd_data      = ram_dout;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.count        = cnt_q;
   assign bus.full         = flg_q.full;
   assign bus.empty        = flg_q.empty;
   assign bus.almost_full  = flg_q.almost_full;
   assign bus.almost_empty = flg_q.almost_empty;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: directed scenarios plus random traffic vs a queue model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: model drops pushes when full and pops when empty.
module tb_ram_fifo_ctrl;

   localparam int WIDTH = 8;
   localparam int ADDR  = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram_fifo_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

   ram_fifo_ctrl #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .AF_LEVEL(AF), .AE_LEVEL(AE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: plain queue of stored words plus sticky bits and last output.
   logic [WIDTH-1:0] m_q [$];
   logic             m_ovf, m_udf, m_vld;
   logic [WIDTH-1:0] m_dat;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic w, input logic [WIDTH-1:0] d, input logic r,
                             input logic rs);
      int sz;
      if (rs) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_vld = 1'b0;
         m_dat = '0;
      end else begin
         sz = m_q.size();
         if (w && sz == DEPTH) m_ovf = 1'b1;
         if (r && sz == 0)     m_udf = 1'b1;
         m_vld = 1'b0;
         if (r && sz > 0) begin
            m_dat = m_q.pop_front();
            m_vld = 1'b1;
         end
         if (w && sz < DEPTH) m_q.push_back(d);
      end
   endtask

   task automatic check_all();
      int sz;
      sz = m_q.size();
      check("count",        32'(bus.count),        32'(sz));
      check("full",         32'(bus.full),         32'(sz == DEPTH));
      check("empty",        32'(bus.empty),        32'(sz == 0));
      check("almost_full",  32'(bus.almost_full),  32'(sz >= AF));
      check("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE));
      check("overflow",     32'(bus.overflow),     32'(m_ovf));
      check("underflow",    32'(bus.underflow),    32'(m_udf));
      check("rd_valid",     32'(bus.rd_valid),     32'(m_vld));
      check("rd_data",      32'(bus.rd_data),      32'(m_dat));
   endtask

   // One clock cycle: drive, clock, advance model, compare.
   task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic rs);
      bus.wr_en   = w;
      bus.wr_data = d;
      bus.rd_en   = r;
      rst         = rs;
      @(posedge clk);
      model_edge(w, d, r, rs);
      #1;
      check_all();
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0; rst = 1'b1;
      m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0; m_dat = '0;

      // 1: reset, then fill with 0x10..0x1F
      cyc(0, 8'h00, 0, 1);
      check("t1_reset_empty", 32'(bus.empty), 32'd1);
      check("t1_reset_ae",    32'(bus.almost_empty), 32'd1);
      for (int i = 0; i < 16; i++) begin
         cyc(1, 8'(8'h10 + i), 0, 0);
         check("t1_count", 32'(bus.count), 32'(i + 1));
         if (i == 12) check("t1_af_13", 32'(bus.almost_full), 32'd0);
         if (i == 13) check("t1_af_14", 32'(bus.almost_full), 32'd1);
      end
      check("t1_full",  32'(bus.full),  32'd1);
      check("t1_empty", 32'(bus.empty), 32'd0);

      // 2: push while full is rejected
      cyc(1, 8'hAA, 0, 0);
      check("t2_count", 32'(bus.count), 32'd16);
      check("t2_ovf",   32'(bus.overflow), 32'd1);

      // 3: drain in order, then pop on empty
      for (int i = 0; i < 16; i++) begin
         cyc(0, 8'h00, 1, 0);
         check("t3_data",  32'(bus.rd_data),  32'(8'h10 + i));
         check("t3_valid", 32'(bus.rd_valid), 32'd1);
      end
      check("t3_empty", 32'(bus.empty), 32'd1);
      cyc(0, 8'h00, 1, 0);
      check("t3_udf",   32'(bus.underflow), 32'd1);
      check("t3_valid0", 32'(bus.rd_valid), 32'd0);

      // 4: steady push+pop at count 8 across pointer wrap
      cyc(0, 8'h00, 0, 1);
      for (int i = 0; i < 8; i++) cyc(1, 8'(8'h40 + i), 0, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 8'(8'h48 + i), 1, 0);
         check("t4_count", 32'(bus.count),   32'd8);
         check("t4_data",  32'(bus.rd_data), 32'(8'h40 + i));
      end

      // 5: push+pop on empty: pop rejected, no fall-through
      cyc(0, 8'h00, 0, 1);
      cyc(1, 8'h77, 1, 0);
      check("t5_udf",   32'(bus.underflow), 32'd1);
      check("t5_count", 32'(bus.count),     32'd1);
      check("t5_valid", 32'(bus.rd_valid),  32'd0);
      cyc(0, 8'h00, 1, 0);
      check("t5_data",  32'(bus.rd_data),   32'h77);

      // 6: reset right after an accepted pop drops it
      cyc(1, 8'h33, 0, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 1);
      check("t6_valid", 32'(bus.rd_valid), 32'd0);
      check("t6_count", 32'(bus.count),    32'd0);
      check("t6_empty", 32'(bus.empty),    32'd1);
      check("t6_udf",   32'(bus.underflow), 32'd0);
      cyc(1, 8'h5C, 0, 0);
      cyc(0, 8'h00, 1, 0);
      check("t6_data",  32'(bus.rd_data), 32'h5C);

      // Random traffic in phases with different push/pop bias
      for (int ph = 0; ph < 6; ph++) begin
         int wp, rp;
         wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 55;
         rp = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 80 : 55;
         for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
                8'($urandom),
                ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
                ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
